// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its environment: the instruction
// fetch port, the execute handshake, the branch/return unit and status.
interface pc_sequencer_if;
  logic        mem_req;
  logic [10:0] mem_addr;
  logic        mem_rdy;
  logic [15:0] mem_data;

  logic        instr_valid;
  logic [15:0] instr_out;
  logic        instr_ack;

  logic        bsr_en;
  logic        bsr_branch;
  logic        bsr_return;
  logic [9:0]  bsr_s;
  logic [10:0] bsr_old_pc;
  logic [10:0] bsr_new_pc;

  logic [10:0] pc;
  logic [2:0]  depth;
  logic        halted;
  logic        fault;

  // Sequencer side
  modport master (
    output mem_req, mem_addr, instr_valid, instr_out,
           bsr_en, bsr_branch, bsr_return, bsr_s, bsr_old_pc,
           pc, depth, halted, fault,
    input  mem_rdy, mem_data, instr_ack, bsr_new_pc
  );

  // Environment side: memory, execute stage and branch/return unit
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr_out,
           bsr_en, bsr_branch, bsr_return, bsr_s, bsr_old_pc,
           pc, depth, halted, fault,
    output mem_rdy, mem_data, instr_ack, bsr_new_pc
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: fetches instruction words, hands normal instructions to
// execute, and drives the branch/return unit for calls and returns. It tracks
// the nesting depth itself so stack over/underflow is caught before any strobe.
module pc_sequencer #(
  parameter logic [10:0] RESET_PC    = 11'h000,
  parameter int unsigned STACK_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE, ISSUE, CALL, RET, LOAD, HALT, FAULT
  } state_t;

  localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

  state_t      r_state;
  logic [15:0] r_ir;
  logic [10:0] r_pc;
  logic [2:0]  r_depth;
  logic        r_memReq;
  logic        r_instrValid;
  logic [15:0] r_instrOut;
  logic        r_bsrEn;
  logic        r_bsrBranch;
  logic        r_bsrReturn;
  logic [9:0]  r_bsrS;
  logic [10:0] r_bsrOldPc;
  logic        r_halted;
  logic        r_fault;

  logic        w_isCall;
  logic        w_isRet;
  logic        w_isHalt;

  assign w_isCall = (r_ir[15:12] == 4'hE);
  assign w_isRet  = (r_ir[15:11] == 5'b11110);
  assign w_isHalt = (r_ir[15:11] == 5'b11111);

  assign bus.mem_req     = r_memReq;
  assign bus.mem_addr    = r_pc;
  assign bus.instr_valid = r_instrValid;
  assign bus.instr_out   = r_instrOut;
  assign bus.bsr_en      = r_bsrEn;
  assign bus.bsr_branch  = r_bsrBranch;
  assign bus.bsr_return  = r_bsrReturn;
  assign bus.bsr_s       = r_bsrS;
  assign bus.bsr_old_pc  = r_bsrOldPc;
  assign bus.pc          = r_pc;
  assign bus.depth       = r_depth;
  assign bus.halted      = r_halted;
  assign bus.fault       = r_fault;

  // Sequencer FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FETCH;
      r_ir         <= '0;
      r_pc         <= RESET_PC;
      r_depth      <= '0;
      r_memReq     <= 1'b0;
      r_instrValid <= 1'b0;
      r_instrOut   <= '0;
      r_bsrEn      <= 1'b0;
      r_bsrBranch  <= 1'b0;
      r_bsrReturn  <= 1'b0;
      r_bsrS       <= '0;
      r_bsrOldPc   <= '0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_bsrBranch <= 1'b0;
      r_bsrReturn <= 1'b0;
      case (r_state)
        FETCH: begin
          r_bsrEn <= 1'b1;
          // mem_rdy only counts once the request is actually on the bus,
          // which covers the first cycle out of reset.
          if (r_memReq && bus.mem_rdy) begin
            r_ir     <= bus.mem_data;
            r_memReq <= 1'b0;
            r_state  <= DECODE;
          end else begin
            r_memReq <= 1'b1;
          end
        end
        DECODE: begin
          if (w_isCall) begin
            if (r_depth < DEPTH_MAX) begin
              r_bsrBranch <= 1'b1;
              r_bsrS      <= r_ir[9:0];
              r_bsrOldPc  <= r_pc;
              r_state     <= CALL;
            end else begin
              r_fault <= 1'b1;
              r_bsrEn <= 1'b0;
              r_state <= FAULT;
            end
          end else if (w_isRet) begin
            if (r_depth != 3'd0) begin
              r_bsrReturn <= 1'b1;
              r_state     <= RET;
            end else begin
              r_fault <= 1'b1;
              r_bsrEn <= 1'b0;
              r_state <= FAULT;
            end
          end else if (w_isHalt) begin
            r_halted <= 1'b1;
            r_bsrEn  <= 1'b0;
            r_state  <= HALT;
          end else begin
            r_instrValid <= 1'b1;
            r_instrOut   <= r_ir;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.instr_ack) begin
            r_instrValid <= 1'b0;
            r_pc         <= r_pc + 11'd1;
            r_memReq     <= 1'b1;
            r_state      <= FETCH;
          end
        end
        CALL: begin
          r_depth <= r_depth + 3'd1;
          r_state <= LOAD;
        end
        RET: begin
          r_depth <= r_depth - 3'd1;
          r_state <= LOAD;
        end
        LOAD: begin
          // The branch/return unit already computed the target; take it as is.
          r_pc     <= bus.bsr_new_pc;
          r_memReq <= 1'b1;
          r_state  <= FETCH;
        end
        HALT, FAULT: begin
          r_bsrEn  <= 1'b0;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a random
// instruction stream, checked against a PC/call-stack model of the program.
module tb_pc_sequencer;

  localparam logic [10:0] RESET_PC = 11'h000;
  localparam int          MAX_NEST = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checkCount = 0;
  int errorCount = 0;

  // Program-level model: expected PC and the stack of return addresses
  logic [10:0] modelPc;
  logic [10:0] modelStack[$];

  // Behavioural branch/return unit driving bsr_new_pc
  logic [10:0] bsrNewPc;
  logic [10:0] bsrStack[$];

  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_PC   (RESET_PC),
    .STACK_DEPTH(MAX_NEST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Branch/return unit: registers the target on the strobe edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsrNewPc <= '0;
      bsrStack.delete();
    end else if (bus.bsr_branch) begin
      bsrNewPc <= bus.bsr_old_pc + {1'b0, bus.bsr_s};
      bsrStack.push_back(bus.bsr_old_pc + 11'd1);
    end else if (bus.bsr_return) begin
      if (bsrStack.size() > 0) bsrNewPc <= bsrStack.pop_back();
    end
  end

  assign bus.bsr_new_pc = bsrNewPc;

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] randNormal();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:13] == 3'b111) w[15] = 1'b0;
    return w;
  endfunction

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_rdy   = 1'b0;
    bus.instr_ack = 1'b0;
    modelPc = RESET_PC;
    modelStack.delete();
    repeat (2) @(negedge clk);
    checkOutput("rstPc", bus.pc, RESET_PC);
    checkOutput("rstDepth", bus.depth, 0);
    checkOutput("rstMemReq", bus.mem_req, 0);
    checkOutput("rstValid", bus.instr_valid, 0);
    checkOutput("rstBranch", bus.bsr_branch, 0);
    checkOutput("rstReturn", bus.bsr_return, 0);
    checkOutput("rstBsrEn", bus.bsr_en, 0);
    checkOutput("rstHalted", bus.halted, 0);
    checkOutput("rstFault", bus.fault, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("firstReq", bus.mem_req, 1);
    checkOutput("firstAddr", bus.mem_addr, RESET_PC);
    checkOutput("firstBsrEn", bus.bsr_en, 1);
  endtask

  // Serve one fetch, optionally stalling; returns with the word in DECODE
  task automatic fetchWord(input logic [15:0] word, input int stall);
    int waitCount;
    waitCount = 0;
    while (bus.mem_req !== 1'b1 && waitCount < 20) begin
      @(negedge clk);
      waitCount++;
    end
    checkOutput("fetchReq", bus.mem_req, 1);
    checkOutput("fetchAddr", bus.mem_addr, modelPc);
    for (int s = 0; s < stall; s++) begin
      bus.mem_rdy = 1'b0;
      @(negedge clk);
      checkOutput("stallReq", bus.mem_req, 1);
      checkOutput("stallAddr", bus.mem_addr, modelPc);
    end
    bus.mem_rdy  = 1'b1;
    bus.mem_data = word;
    @(negedge clk);
    bus.mem_rdy  = 1'b0;
    bus.mem_data = 16'($urandom);
    checkOutput("reqDrop", bus.mem_req, 0);
  endtask

  // After HALT or FAULT: nothing moves and nothing is requested
  task automatic checkFrozen(input string tag);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput({tag, "Req"}, bus.mem_req, 0);
      checkOutput({tag, "Pc"}, bus.pc, modelPc);
      checkOutput({tag, "Depth"}, bus.depth, modelStack.size());
      checkOutput({tag, "Strobe"}, {bus.bsr_branch, bus.bsr_return}, 0);
      checkOutput({tag, "BsrEn"}, bus.bsr_en, 0);
      checkOutput({tag, "Valid"}, bus.instr_valid, 0);
    end
  endtask

  // Run one instruction word through the sequencer and check its effect
  task automatic applyStimulus(input logic [15:0] word, input int stall, input int ackDelay);
    logic [10:0] target;
    fetchWord(word, stall);
    @(negedge clk);
    if (word[15:12] == 4'hE) begin
      if (modelStack.size() < MAX_NEST) begin
        target = modelPc + {1'b0, word[9:0]};
        checkOutput("callStrobe", {bus.bsr_branch, bus.bsr_return}, 2'b10);
        checkOutput("callS", bus.bsr_s, word[9:0]);
        checkOutput("callOldPc", bus.bsr_old_pc, modelPc);
        @(negedge clk);
        checkOutput("callPulse", {bus.bsr_branch, bus.bsr_return}, 0);
        checkOutput("callDepth", bus.depth, modelStack.size() + 1);
        @(negedge clk);
        modelStack.push_back(modelPc + 11'd1);
        modelPc = target;
        checkOutput("callPc", bus.pc, modelPc);
        checkOutput("callReq", bus.mem_req, 1);
      end else begin
        checkOutput("ovfFault", bus.fault, 1);
        checkOutput("ovfStrobe", {bus.bsr_branch, bus.bsr_return}, 0);
        checkFrozen("ovf");
      end
    end else if (word[15:11] == 5'b11110) begin
      if (modelStack.size() > 0) begin
        checkOutput("retStrobe", {bus.bsr_branch, bus.bsr_return}, 2'b01);
        @(negedge clk);
        checkOutput("retPulse", {bus.bsr_branch, bus.bsr_return}, 0);
        checkOutput("retDepth", bus.depth, modelStack.size() - 1);
        @(negedge clk);
        modelPc = modelStack.pop_back();
        checkOutput("retPc", bus.pc, modelPc);
        checkOutput("retReq", bus.mem_req, 1);
      end else begin
        checkOutput("unfFault", bus.fault, 1);
        checkOutput("unfStrobe", {bus.bsr_branch, bus.bsr_return}, 0);
        checkFrozen("unf");
      end
    end else if (word[15:11] == 5'b11111) begin
      checkOutput("haltFlag", bus.halted, 1);
      checkOutput("haltFault", bus.fault, 0);
      checkFrozen("halt");
    end else begin
      checkOutput("issueValid", bus.instr_valid, 1);
      checkOutput("issueInstr", bus.instr_out, word);
      for (int d = 0; d < ackDelay; d++) begin
        @(negedge clk);
        checkOutput("holdValid", bus.instr_valid, 1);
        checkOutput("holdPc", bus.pc, modelPc);
      end
      bus.instr_ack = 1'b1;
      @(negedge clk);
      bus.instr_ack = 1'b0;
      modelPc = modelPc + 11'd1;
      checkOutput("ackValid", bus.instr_valid, 0);
      checkOutput("ackPc", bus.pc, modelPc);
      checkOutput("ackReq", bus.mem_req, 1);
    end
  endtask

  // Scenario sequence
  initial begin
    bus.mem_rdy   = 1'b0;
    bus.mem_data  = '0;
    bus.instr_ack = 1'b0;
    modelPc = RESET_PC;

    // Stalled first fetch, then walk up to pc=010
    applyReset();
    applyStimulus(16'h1234, 3, 1);
    checkOutput("stallPcNext", bus.pc, 11'h001);
    for (int i = 0; i < 15; i++)
      applyStimulus(randNormal(), $urandom_range(0, 2), $urandom_range(0, 2));

    // Call and matching return, then return with an empty stack
    applyStimulus(16'hE005, 0, 0);
    checkOutput("call015", bus.pc, 11'h015);
    checkOutput("callDepth1", bus.depth, 1);
    applyStimulus(16'hF000, 1, 0);
    checkOutput("ret011", bus.pc, 11'h011);
    checkOutput("retDepth0", bus.depth, 0);
    applyStimulus(16'hF000, 0, 0);

    // Five nested calls overflow on the fifth
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(16'hE001, $urandom_range(0, 1), 0);
    checkOutput("ovfDepth4", bus.depth, 4);

    // Reach 7FF through calls, wrap on increment, then halt
    applyReset();
    applyStimulus(16'hE3FF, 0, 0);
    applyStimulus(16'hE3FF, 0, 0);
    applyStimulus(randNormal(), 0, 0);
    checkOutput("pc7ff", bus.pc, 11'h7FF);
    applyStimulus(randNormal(), 0, 1);
    checkOutput("wrapPc", bus.pc, 11'h000);
    applyStimulus(16'hF800, 0, 0);

    // Reset arriving while the call target is being loaded
    applyReset();
    fetchWord(16'hE123, 0);
    @(negedge clk);
    checkOutput("loadRstCall", bus.bsr_branch, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("loadRstPc", bus.pc, RESET_PC);
    checkOutput("loadRstDepth", bus.depth, 0);
    checkOutput("loadRstStrobe", {bus.bsr_branch, bus.bsr_return, bus.mem_req, bus.instr_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelPc = RESET_PC;
    modelStack.delete();
    @(negedge clk);
    checkOutput("loadRstAfterPc", bus.pc, RESET_PC);
    checkOutput("loadRstAfterReq", bus.mem_req, 1);

    // Random legal instruction stream
    applyReset();
    for (int i = 0; i < 80; i++) begin
      int op;
      logic [15:0] w;
      op = $urandom_range(0, 9);
      if (op < 3 && modelStack.size() < MAX_NEST)
        w = {4'hE, 2'($urandom), 10'($urandom)};
      else if (op < 5 && modelStack.size() > 0)
        w = {5'b11110, 11'($urandom)};
      else
        w = randNormal();
      applyStimulus(w, $urandom_range(0, 3), $urandom_range(0, 3));
      checkOutput("rndDepth", bus.depth, modelStack.size());
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
